pc_predict_fetch: RTL
=====================

# pc_predict_fetch

- Fetch-stage program-counter generator with a direct-mapped branch target buffer (BTB) and 2-bit saturating direction counters.
- Produces the fetch PC and the predicted next PC (PPC) that travels down the pipeline to Execute.
- Consumes the Execute-stage resolution: on a misprediction it redirects fetch, and on every resolved branch it trains the BTB.
- It is the fetch-side counterpart of Execute's PC evaluation: it issues the PPC that Execute checks, and it absorbs the corrected PC that Execute returns.

## Interface

Parameters:
- WIDTH, 32, PC and target width in bits.
- IDX_BITS, 4, BTB index width; the BTB has 2^IDX_BITS entries.
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned.

Ports (clock and reset first):
- i_Clk  in  1  system clock; all state updates on the rising edge.
- i_Rst  in  1  asynchronous, active-high reset.
- i_Stall  in  1  hold the fetch PC; from the hazard unit.
- i_Redirect  in  1  misprediction detected in Execute; forces fetch to i_Redirect_PC.
- i_Redirect_PC  in  WIDTH  corrected PC from Execute.
- i_Upd_En  in  1  a branch or jump resolved in Execute this cycle.
- i_Upd_PC  in  WIDTH  PC of the resolved branch.
- i_Upd_Target  in  WIDTH  resolved branch target (the ALU result).
- i_Upd_Taken  in  1  resolved direction: 1 = taken.
- o_PC  out  WIDTH  current fetch PC (registered).
- o_PPC  out  WIDTH  predicted next PC for o_PC (combinational).
- o_Pred_Taken  out  1  1 when o_PPC comes from the BTB rather than PC+4.

## Operation

- PCs are word-aligned.
  - Index = PC[IDX_BITS+1:2].
  - Tag = PC[WIDTH-1:IDX_BITS+2].
  - Bits [1:0] are ignored on every input and forced to 0 when loaded into o_PC.
- Each BTB entry holds: valid, tag, target (WIDTH), ctr (2 bits).
- Lookup (combinational on o_PC):
  - hit = valid && (tag matches o_PC's tag).
  - o_Pred_Taken = hit && ctr[1].
  - o_PPC = o_Pred_Taken ? target : o_PC + 4. The +4 wraps modulo 2^WIDTH.
- PC register priority, evaluated every edge:
  1. Reset: o_PC = RESET_PC.
  2. i_Redirect: o_PC <= {i_Redirect_PC[WIDTH-1:2], 2'b00}.
  3. i_Stall: o_PC holds.
  4. Otherwise: o_PC <= o_PPC.
- Update on i_Upd_En, indexed and tagged by i_Upd_PC:
  - Hit, taken: ctr saturating-increments (max 2'b11); target <= i_Upd_Target.
  - Hit, not taken: ctr saturating-decrements (min 2'b00); target unchanged.
  - Miss, taken: allocate. Write valid=1, the new tag and the target, and set ctr=2'b10 (weakly taken). Any existing entry at that index is overwritten.
  - Miss, not taken: no write.
- Training is independent of i_Stall and i_Redirect: an update is applied even in a redirect or stall cycle.
- Reset clears every valid bit, sets every ctr to 2'b01, and sets every target to 0.

## Timing

- Reset values: o_PC = RESET_PC; o_Pred_Taken = 0; o_PPC = RESET_PC + 4 (the BTB is empty).
- First post-reset edge: o_PC moves to RESET_PC + 4 unless a stall or redirect is asserted.
- Redirect latency is one cycle: i_Redirect sampled at edge N gives o_PC = i_Redirect_PC after edge N. The PPC for that address is valid in the same cycle.
- o_PPC and o_Pred_Taken settle in the same cycle as o_PC; there is no extra pipeline stage.
- BTB writes take effect at the edge. A lookup in the same cycle as a write to the same index sees the old contents; the new contents are visible from the next cycle.
- Redirect and stall in the same cycle: redirect wins.
- Asserting reset mid-operation immediately (asynchronously) restores all reset values and discards BTB contents. The first update is accepted on the first edge after reset deasserts.

## Test plan

- Reset / sequential fetch:
  - Stimulus: RESET_PC = 0x100, no stall, redirect or update.
  - Required: o_PC is 0x100, 0x104, 0x108 on consecutive cycles; o_Pred_Taken = 0 throughout.
- Allocate and predict:
  - Stimulus: update with i_Upd_PC = 0x108, i_Upd_Target = 0x200, taken; then redirect to 0x108.
  - Required: in the cycle o_PC = 0x108, o_PPC = 0x200 and o_Pred_Taken = 1; in the next cycle o_PC = 0x200.
- Counter hysteresis:
  - Stimulus: starting from the allocated entry (ctr = 2'b10), apply one not-taken update for 0x108.
  - Required: ctr = 01 and a lookup of 0x108 predicts 0x10C.
  - Stimulus: apply two taken updates.
  - Required: ctr = 11. Three further not-taken updates reach 00 and saturate there (a fourth leaves it at 00).
- Stall vs redirect:
  - Stimulus: hold i_Stall = 1 for 3 cycles at o_PC = 0x10C.
  - Required: o_PC stays 0x10C.
  - Stimulus: assert i_Redirect with i_Redirect_PC = 0x303 during the stall.
  - Required: o_PC = 0x300 on the next cycle.
- Alias, same-cycle write and reset:
  - Stimulus: with IDX_BITS = 4, allocate 0x040 → 0x500 and then 0x440 → 0x600 (same index, different tag).
  - Required: a lookup of 0x040 misses and predicts 0x044.
  - Stimulus: a lookup coinciding with an update to the same index.
  - Required: the lookup returns the old prediction.
  - Stimulus: assert i_Rst between clock edges.
  - Required: o_PC is 0x100 immediately, and a lookup of 0x440 afterward misses.

Source files
------------

// File: rtl/pc_predict_fetch.sv
// Fetch PC generator with a direct-mapped BTB and 2-bit direction counters.
// Issues the fetch PC and its prediction, and absorbs redirects and training from Execute.
module pc_predict_fetch #(
  parameter int                 WIDTH    = 32,
  parameter int                 IDX_BITS = 4,
  parameter logic [WIDTH-1:0]   RESET_PC = '0
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Stall,
  input  logic             i_Redirect,
  input  logic [WIDTH-1:0] i_Redirect_PC,
  input  logic             i_Upd_En,
  input  logic [WIDTH-1:0] i_Upd_PC,
  input  logic [WIDTH-1:0] i_Upd_Target,
  input  logic             i_Upd_Taken,
  output logic [WIDTH-1:0] o_PC,
  output logic [WIDTH-1:0] o_PPC,
  output logic             o_Pred_Taken
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_W   = WIDTH - IDX_BITS - 2;

  logic [WIDTH-1:0]    pc_q;
  logic                valid_q  [ENTRIES];
  logic [TAG_W-1:0]    tag_q    [ENTRIES];
  logic [WIDTH-1:0]    target_q [ENTRIES];
  logic [1:0]          ctr_q    [ENTRIES];

  logic [IDX_BITS-1:0] look_idx;
  logic [TAG_W-1:0]    look_tag;
  logic                look_hit;
  logic [IDX_BITS-1:0] upd_idx;
  logic [TAG_W-1:0]    upd_tag;
  logic                upd_hit;
  logic                unused_low_bits;

  // Low address bits never matter: instructions are word-aligned.
  assign unused_low_bits = ^{i_Redirect_PC[1:0], i_Upd_PC[1:0], i_Upd_Target[1:0]};

  assign look_idx = pc_q[IDX_BITS+1:2];
  assign look_tag = pc_q[WIDTH-1:IDX_BITS+2];
  assign look_hit = valid_q[look_idx] && (tag_q[look_idx] == look_tag);

  assign upd_idx  = i_Upd_PC[IDX_BITS+1:2];
  assign upd_tag  = i_Upd_PC[WIDTH-1:IDX_BITS+2];
  assign upd_hit  = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  always_comb begin
    o_Pred_Taken = look_hit && ctr_q[look_idx][1];
    o_PPC        = o_Pred_Taken ? target_q[look_idx] : pc_q + WIDTH'(4);
    o_PC         = pc_q;
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      pc_q <= {RESET_PC[WIDTH-1:2], 2'b00};
    end else if (i_Redirect) begin
      pc_q <= {i_Redirect_PC[WIDTH-1:2], 2'b00};
    end else if (!i_Stall) begin
      pc_q <= o_PPC;
    end
  end

  // Training runs regardless of stall/redirect; same-cycle lookups see old contents.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (i_Upd_En) begin
      if (upd_hit) begin
        if (i_Upd_Taken) begin
          ctr_q[upd_idx]    <= (ctr_q[upd_idx] == 2'b11) ? 2'b11 : ctr_q[upd_idx] + 2'd1;
          target_q[upd_idx] <= {i_Upd_Target[WIDTH-1:2], 2'b00};
        end else begin
          ctr_q[upd_idx]    <= (ctr_q[upd_idx] == 2'b00) ? 2'b00 : ctr_q[upd_idx] - 2'd1;
        end
      end else if (i_Upd_Taken) begin
        valid_q[upd_idx]  <= 1'b1;
        tag_q[upd_idx]    <= upd_tag;
        target_q[upd_idx] <= {i_Upd_Target[WIDTH-1:2], 2'b00};
        ctr_q[upd_idx]    <= 2'b10;
      end
    end
  end

endmodule
